// File: rtl/systolic_input_feeder_pkg.sv
// Shared definitions for the systolic array input feeder and its companion
// output accumulate buffer.
// Build option: SYSTOLIC_FEEDER_SKEW_EN selects the diagonally skewed drain
// (7 cycles). When it is left undefined, all rows issue together (4 cycles).
package systolic_pkg;

   localparam int DATA_W         = 32;
   localparam int N              = 4;
   localparam int DEPTH          = 16;
   localparam int SKEW_DRAIN_LEN = 7;
   localparam int FLAT_DRAIN_LEN = 4;

`ifdef SYSTOLIC_FEEDER_SKEW_EN
   localparam bit SKEW_EN   = 1'b1;
   localparam int DRAIN_LEN = SKEW_DRAIN_LEN;
`else
   localparam bit SKEW_EN   = 1'b0;
   localparam int DRAIN_LEN = FLAT_DRAIN_LEN;
`endif

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } feeder_state_t;

   // Number of drain cycles by which row r trails row 0.
   function automatic int row_lag(input int r);
      return SKEW_EN ? r : 0;
   endfunction

endpackage

// File: rtl/systolic_input_feeder_if.sv
// Bus bundle between the DMA stream source, the feeder and the array rows.
// Handshake: a word moves on a rising clock edge where i_valid && o_ready are
// both high. o_ready comes straight from the state register, and the source
// must hold i_data stable until that edge. The row outputs have no
// back-pressure: the array consumes a row operand in every cycle where its
// o_validN is high.
interface systolic_input_feeder_if;
   import systolic_pkg::*;

   logic [DATA_W-1:0] i_data;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] o_data1;
   logic [DATA_W-1:0] o_data2;
   logic [DATA_W-1:0] o_data3;
   logic [DATA_W-1:0] o_data4;
   logic              o_valid1;
   logic              o_valid2;
   logic              o_valid3;
   logic              o_valid4;
   logic              o_busy;
   logic              o_done;
   feeder_state_t     dbg_state;

   modport slave (
      input  i_data, i_valid,
      output o_ready,
      output o_data1, o_data2, o_data3, o_data4,
      output o_valid1, o_valid2, o_valid3, o_valid4,
      output o_busy, o_done, dbg_state
   );

   modport master (
      output i_data, i_valid,
      input  o_ready,
      input  o_data1, o_data2, o_data3, o_data4,
      input  o_valid1, o_valid2, o_valid3, o_valid4,
      input  o_busy, o_done, dbg_state
   );

endinterface

// File: rtl/systolic_input_feeder_row_issue.sv
// One row of the feeder output stage. It picks the column that is due for
// this row in the coming drain step and registers it together with its valid.
// The row lag comes from systolic_pkg::row_lag, which in turn depends on
// SYSTOLIC_FEEDER_SKEW_EN.
module feeder_row_issue
   import systolic_pkg::*;
#(
   parameter int R = 0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [2:0]                 i_t,
   input  logic [N-1:0][DATA_W-1:0]   i_words,
   input  logic                       i_drain,
   output logic [DATA_W-1:0]          o_data,
   output logic                       o_valid
);

   localparam int LAG = row_lag(R);

   logic [3:0]        col_ofs;
   logic              issue_d;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;

   // Column offset for step t. A step before this row's start wraps to a large
   // value, so one unsigned bound check covers both ends of the window.
   always_comb begin
      col_ofs = {1'b0, i_t} - 4'(LAG);
      issue_d = i_drain && (col_ofs <= 4'd3);
   end

   // Registered row operand. The data holds its last value when the row is idle.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= issue_d;
         if (issue_d) begin
            data_q <= i_words[col_ofs[1:0]];
         end
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;

endmodule

// File: rtl/systolic_input_feeder.sv
// Systolic array input feeder. It collects a 16-word row-major tile from the
// DMA stream and then drains it into the four array rows.
// Build option: SYSTOLIC_FEEDER_SKEW_EN selects the diagonal skew (7-cycle
// drain). The default build issues all rows in lockstep (4-cycle drain).
module systolic_input_feeder
   import systolic_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   systolic_input_feeder_if.slave   bus
);

   localparam logic [2:0] T_LAST    = 3'(DRAIN_LEN - 1);
   localparam logic [4:0] WR_LAST   = 5'(DEPTH - 1);

   feeder_state_t     state_q, state_d;
   logic [4:0]        wr_cnt_q, wr_cnt_d;
   logic [2:0]        t_q, t_d;
   logic              done_q, done_d;
   logic              accept;
   logic              drain_d;
   logic [DATA_W-1:0] buf_q [DEPTH];

   logic [N-1:0][DATA_W-1:0] row_words [N];
   logic [DATA_W-1:0]        row_data  [N];
   logic                     row_valid [N];

   assign accept  = (state_q == FILL) && bus.i_valid;
   assign drain_d = (state_d == DRAIN);

   // Next-state logic for the fill/drain sequencer and its counters.
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      t_d      = t_q;
      done_d   = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               if (wr_cnt_q == WR_LAST) begin
                  state_d  = DRAIN;
                  wr_cnt_d = '0;
                  t_d      = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + 5'd1;
               end
            end
         end
         DRAIN: begin
            if (t_q == T_LAST) begin
               state_d = FILL;
               t_d     = '0;
               done_d  = 1'b1;
            end else begin
               t_d = t_q + 3'd1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Sequencer registers. A reset abandons any partial tile.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= FILL;
         wr_cnt_q <= '0;
         t_q      <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         t_q      <= t_d;
         done_q   <= done_d;
      end
   end

   // Tile storage. Its contents are meaningless until a full tile has landed.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         buf_q[wr_cnt_q[3:0]] <= bus.i_data;
      end
   end

   // The row stages are fed the next-step counter, so the first operand
   // appears in the cycle right after the edge that accepts word 15.
   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign row_words[r][c] = buf_q[r*N + c];
      end
      feeder_row_issue #(.R(r)) u_row_issue (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_t     (t_d),
         .i_words (row_words[r]),
         .i_drain (drain_d),
         .o_data  (row_data[r]),
         .o_valid (row_valid[r])
      );
   end

   assign bus.o_ready   = (state_q == FILL);
   assign bus.o_busy    = (state_q == DRAIN);
   assign bus.o_done    = done_q;
   assign bus.dbg_state = state_q;
   assign bus.o_data1   = row_data[0];
   assign bus.o_data2   = row_data[1];
   assign bus.o_data3   = row_data[2];
   assign bus.o_data4   = row_data[3];
   assign bus.o_valid1  = row_valid[0];
   assign bus.o_valid2  = row_valid[1];
   assign bus.o_valid3  = row_valid[2];
   assign bus.o_valid4  = row_valid[3];

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Bench for systolic_input_feeder. A tile model expands every completed
// 16-word tile into the per-cycle output picture the array should see. A
// monitor then compares every cycle against that picture.
module tb_systolic_input_feeder;

   localparam int W     = 32;
   localparam int REC_W = 4*W + 7;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
   localparam int TB_LEN  = 7;
   localparam bit TB_SKEW = 1'b1;
`else
   localparam int TB_LEN  = 4;
   localparam bit TB_SKEW = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_input_feeder_if bus();

   systolic_input_feeder dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   logic [REC_W-1:0] exp_q[$];
   logic [W-1:0]     tile[$];
   logic [W-1:0]     hold [4] = '{default: '0};
   int               n_cmp = 0;
   int               n_err = 0;

   function automatic logic [REC_W-1:0] pack_rec(input logic done, input logic busy,
                                                  input logic ready, input logic [3:0] v,
                                                  input logic [W-1:0] d0, input logic [W-1:0] d1,
                                                  input logic [W-1:0] d2, input logic [W-1:0] d3);
      return {done, busy, ready, v, d3, d2, d1, d0};
   endfunction

   // Reference model: once 16 words are collected, list what each drain
   // step shows. Row r shows column (k - r) with skew, or column k without
   // it. The data of an idle row keeps its last value.
   task automatic model_accept(input logic [W-1:0] d);
      tile.push_back(d);
      if (tile.size() == 16) begin
         for (int k = 0; k < TB_LEN; k++) begin
            logic [3:0] v;
            v = '0;
            for (int r = 0; r < 4; r++) begin
               int col;
               col = TB_SKEW ? (k - r) : k;
               if (col >= 0 && col < 4) begin
                  v[r]    = 1'b1;
                  hold[r] = tile[4*r + col];
               end
            end
            exp_q.push_back(pack_rec(1'b0, 1'b1, 1'b0, v, hold[0], hold[1], hold[2], hold[3]));
         end
         exp_q.push_back(pack_rec(1'b1, 1'b0, 1'b1, 4'b0, hold[0], hold[1], hold[2], hold[3]));
         tile.delete();
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [REC_W-1:0] exp_rec;
      logic [REC_W-1:0] act_rec;
      forever begin
         @(negedge clk);
         if (!rst_n)
            exp_rec = pack_rec(1'b0, 1'b0, 1'b1, 4'b0, '0, '0, '0, '0);
         else if (exp_q.size() > 0)
            exp_rec = exp_q.pop_front();
         else
            exp_rec = pack_rec(1'b0, 1'b0, 1'b1, 4'b0, hold[0], hold[1], hold[2], hold[3]);
         act_rec = pack_rec(bus.o_done, bus.o_busy, bus.o_ready,
                            {bus.o_valid4, bus.o_valid3, bus.o_valid2, bus.o_valid1},
                            bus.o_data1, bus.o_data2, bus.o_data3, bus.o_data4);
         n_cmp++;
         if (act_rec !== exp_rec) begin
            n_err++;
            $display("FAIL cycle_outputs @%0t {done,busy,ready,v4..1,d4..d1} got=%h want=%h",
                     $time, act_rec, exp_rec);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Callers enter just after a rising edge. The task samples o_ready in mid-cycle.
   task automatic send_cycle(input logic v, input logic [W-1:0] d, output logic acc);
      bus.i_valid = v;
      bus.i_data  = d;
      @(negedge clk);
      acc = v && bus.o_ready && rst_n;
      @(posedge clk);
      #1;
      if (acc) model_accept(d);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) send_cycle(1'b0, '0, acc);
   endtask

   task automatic send_word(input logic [W-1:0] d, input int gap);
      logic acc;
      int   tries;
      idle(gap);
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 40) begin
         send_cycle(1'b1, d, acc);
         tries++;
      end
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout word=%h got=no_accept want=accept_within_40", d);
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tile.delete();
      exp_q.delete();
      for (int r = 0; r < 4; r++) hold[r] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic acc;
      int   waited;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Back-to-back fill 0x00..0x0F
      for (int i = 0; i < 16; i++) send_word(W'(i), 0);
      idle(TB_LEN + 2);

      // Gappy fill, valid toggling
      for (int i = 0; i < 16; i++) send_word(32'h100 + W'(i), 1);
      idle(TB_LEN + 2);

      // Source holds 0xDEAD through the drain; it must not be taken
      for (int i = 0; i < 16; i++) send_word(32'h200 + W'(i), 0);
      for (int i = 0; i < TB_LEN; i++) send_cycle(1'b1, 32'hDEAD, acc);
      bus.i_valid = 1'b0;
      for (int i = 0; i < 16; i++) send_word(32'h300 + W'(i), 0);
      idle(TB_LEN + 2);

      // Reset after 9 accepts, then a fresh tile
      for (int i = 0; i < 9; i++) send_word(32'hBAD0 + W'(i), 0);
      do_reset();
      idle(5);
      for (int i = 0; i < 16; i++) send_word(32'h20 + W'(i), 0);
      idle(TB_LEN + 2);

      // Two tiles back to back; tile 2 starts in the done cycle
      for (int i = 0; i < 32; i++) send_word($urandom, 0);
      idle(TB_LEN + 2);

      // Random tiles with random gaps
      for (int t = 0; t < 4; t++)
         for (int i = 0; i < 16; i++) send_word($urandom, $urandom_range(0, 3));

      // Wait for the scoreboard to drain
      waited = 0;
      while (exp_q.size() > 0 && waited < 50) begin
         idle(1);
         waited++;
      end
      idle(3);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL pending_outputs got=%0d want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/systolic_input_feeder.md
Name: systolic_input_feeder

Overview:
- Input-side counterpart of the 4x4 systolic array's output accumulate buffer.
- Accepts a serial stream of 16 32-bit words from the AXI DMA (MM2S side) and holds them in a 4x4 buffer.
- Buffer is row-major: words 0-3 belong to row 1, 4-7 to row 2, 8-11 to row 3, 12-15 to row 4.
- Then drives the four array row inputs in parallel, diagonally skewed, with per-row valids.

Parameters:
- DATA_W, 32, width of every data word.
- N, 4, array dimension. Fixed at 4; the port list assumes four rows.
- DEPTH, 16, buffer depth, equal to N*N.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_data  input  32  serial input word.
- i_valid  input  1  i_data valid; a word is accepted on an edge where i_valid && o_ready.
- o_ready  output  1  feeder can accept a word.
- o_data1..o_data4  output  32 each  row 1..4 operands to the array.
- o_valid1..o_valid4  output  1 each  row 1..4 operand valid.
- o_busy  output  1  high while draining.
- o_done  output  1  one-cycle pulse when a 16-word tile has been fully issued.

Behaviour:
- Reset: asynchronous, active-low, so all state clears immediately on i_rst low.
  - State goes to FILL; wr_cnt=0, t=0.
  - o_ready=1; all o_valid*, o_busy and o_done are 0; all o_data* are 0.
  - Buffer contents are don't-care.
- Reset mid-FILL or mid-DRAIN discards the partial tile. No outputs are issued after reset is released until a new 16-word tile completes.
- o_ready equals (state==FILL). It is decoded from the state register, with no combinational path from i_valid.
- FILL:
  - Each accept writes buf[wr_cnt] and increments wr_cnt (5-bit).
  - Words presented while o_ready=0 are ignored and not stored.
  - Gaps in i_valid are allowed.
  - The edge accepting word 15 (wr_cnt==15) moves state to DRAIN, sets t=0 and clears wr_cnt.
- DRAIN:
  - t is a 3-bit counter advancing every cycle; the array has no back-pressure.
  - All outputs are registered. In the cycle where the DRAIN counter equals t, row r (r=0..3) drives o_valid(r+1)=1 and o_data(r+1)=buf[4r+(t-r)] when 0<=t-r<=3.
  - Otherwise o_valid(r+1)=0 and o_data holds its last value.
  - o_valid1 and buf[0] first appear in the cycle immediately after the edge that accepted word 15. This is 1-cycle latency from the last accept.
  - DRAIN lasts 7 cycles (t=0..6); o_busy=1 throughout.
- After t==6:
  - State returns to FILL and o_ready=1.
  - o_done=1 for exactly that first FILL cycle.
  - A word may be accepted in that same cycle.
- Simultaneous events: i_valid during DRAIN is ignored, and the source must hold the word until o_ready returns. o_done and a new accept in the same cycle are both legal.
- The buffer is single-bank. Refill cannot overlap drain.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_SKEW_EN.
- Defined: the diagonal skew above applies. Row r lags row 1 by r cycles, and DRAIN is 7 cycles.
- Undefined: no skew. All four rows issue column t in the same cycle for t=0..3, so all o_valid* are high together. DRAIN is 4 cycles, and o_done follows t==3.
- Latency to the first valid is 1 cycle in both builds.

Decomposition:
- Shared package systolic_pkg holds:
  - DATA_W=32, N=4, DEPTH=16.
  - Drain-length constants SKEW_DRAIN_LEN=7 and FLAT_DRAIN_LEN=4.
  - Typedef feeder_state_t {FILL, DRAIN}.
- The output accumulate buffer reuses DATA_W, N and DEPTH from this package.
- One sub-module is natural: feeder_row_issue, instantiated 4 times with row index r.
  - Inputs: t, the 4 row words and a drain flag.
  - Outputs: registered o_data and o_valid for that row.

Test Plan:
- Back-to-back fill with words 0x00..0x0F:
  - Cycle after the 16th accept: o_valid1=1, o_data1=0x00.
  - Next cycle: o_data1=0x01, o_data2=0x04.
  - Drain t=3: o_data1..4 = 0x03, 0x06, 0x09, 0x0C.
  - t=6: only o_valid4=1 with 0x0F.
  - Then o_done pulses once and o_ready=1.
- Gappy fill, i_valid toggling 1/0 with words 0x100..0x10F: same drain sequence as above offset by 0x100; no extra words stored.
- i_valid held high with 0xDEAD during DRAIN: o_ready=0, 0xDEAD is never emitted, and the next tile starts at wr_cnt=0.
- Assert i_rst low after 9 accepts, then release: no o_valid* asserts. A fresh tile of 0x20..0x2F drains starting at 0x20.
- Two consecutive tiles with the first accept of tile 2 in the o_done cycle: the word is stored at buf[0]; tile 2 drains correctly and its first valid comes 1 cycle after its 16th accept.
- SYSTOLIC_FEEDER_SKEW_EN undefined: drain t=0 gives o_valid1..4 all 1 with data 0x00, 0x04, 0x08, 0x0C. DRAIN is 4 cycles and o_done follows t==3.
